fancytimer_driver: RTL and testbench
====================================

FANCYTIMER_DRIVER -- requirements
Module: fancytimer_driver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning max cycles spent in WAIT_DONE before abort.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_delay, input, 4, delay code d; timer runs (d+1)*1000 cycles.
REQ-007 SHALL have port cmd_ready, output, 1, FIFO not full.
REQ-008 SHALL have port data, output, 1, serial stream to the timer.
REQ-009 SHALL have port counting, input, 1, timer counting status.
REQ-010 SHALL have port done, input, 1, timer finished.
REQ-011 SHALL have port ack, output, 1, acknowledge to the timer.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port cmd_done, output, 1, one-cycle pulse when a command completes normally.
REQ-014 SHALL have port timeout_err, output, 1, sticky abort flag.

Function
REQ-015 SHALL accept a command on a clk edge with cmd_valid=1 and cmd_ready=1, writing cmd_delay into the FIFO tail.
REQ-016 SHALL drive cmd_ready = not full; when full, cmd_valid is ignored and the FIFO is unchanged.
REQ-017 SHALL implement the states IDLE, SEND, WAIT_DONE, ACK, and GAP.
REQ-018 In IDLE with the FIFO non-empty, the block SHALL pop the head, load shift register {4'b1101, delay}, clear the bit index, and enter SEND on that edge; with the FIFO empty it SHALL stay in IDLE.
REQ-019 SEND SHALL last exactly 8 cycles, driving data = shift register MSB each cycle, shifting left each edge, and entering WAIT_DONE after bit 8.
REQ-020 The serial order SHALL be 1,1,0,1, then d[3],d[2],d[1],d[0], contiguous with no gap cycles.
REQ-021 data SHALL be 0 in IDLE, WAIT_DONE, ACK, and GAP, and SHALL be a function of registered state only.
REQ-022 In WAIT_DONE a 15-bit cycle counter SHALL increment each cycle from 0; done=1 SHALL cause a transition to ACK.
REQ-023 If the counter reaches TIMEOUT_CYCLES-1 with done=0, the block SHALL set timeout_err, discard the command, and go to GAP; done on that same cycle SHALL take precedence and go to ACK.
REQ-024 ACK SHALL last 1 cycle with ack=1 and cmd_done=1, then enter GAP.
REQ-025 GAP SHALL last 1 cycle with data=0, then enter IDLE.
REQ-026 counting SHALL be monitor-only and SHALL NOT affect transitions.
REQ-027 Latency: a command accepted at edge E into an empty FIFO with the FSM in IDLE SHALL have its first data=1 in the cycle after edge E+1.
REQ-028 Back-to-back commands SHALL have at least 2 idle cycles of data=0 between the ack cycle and the next preamble (GAP plus IDLE pop).
REQ-029 Simultaneous push and pop SHALL both take effect, leaving the count unchanged.

Reset
REQ-030 While reset=0 the block SHALL asynchronously force state IDLE, FIFO empty, counter 0, and all outputs data, ack, busy, cmd_done, and timeout_err to 0, with cmd_ready=1.
REQ-031 timeout_err SHALL clear only on reset.
REQ-032 Reset asserted mid-SEND or mid-WAIT_DONE SHALL abort immediately with no ack, and queued commands SHALL be lost.

Verification
REQ-033 Single command d=2, done returned 3000 cycles after the last bit -> data 1,1,0,1,0,0,1,0; ack and cmd_done high for 1 cycle on the edge after done; busy falls after GAP.
REQ-034 Five commands pushed back-to-back with FIFO_DEPTH=4 -> the first is popped at once, cmd_ready drops when full, and all accepted commands are serialized in order with 2-cycle gaps.
REQ-035 With TIMEOUT_CYCLES=16 and done held 0 -> timeout_err=1 after 16 WAIT_DONE cycles, no ack, and the next queued command is sent.
REQ-036 done=1 on the same cycle the timeout fires -> ACK is taken, cmd_done pulses, and timeout_err stays 0.
REQ-037 reset pulled low during bit 5 of SEND -> outputs clear immediately, and after release data stays 0 with cmd_ready=1.
REQ-038 Closed loop with the timer, d=0 -> done asserts about 1000 cycles after the last data bit, and the driver acks and returns to IDLE.

Source files
------------

// File: rtl/fancytimer_driver.sv
// Command-queued serial driver for a delay timer: pops a delay code, shifts out an 8-bit
// frame, waits for the timer's done with a timeout, then acks and inserts a one-cycle gap.
module fancytimer_driver #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_delay,
    output logic       cmd_ready,
    output logic       data,
    input  logic       counting,
    input  logic       done,
    output logic       ack,
    output logic       busy,
    output logic       cmd_done,
    output logic       timeout_err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [14:0] TimeoutLast = 15'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSend, StWaitDone, StAck, StGap} state_e;

    state_e          state_q, state_d;
    logic [3:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      idx_q, idx_d;
    logic [14:0]     wcnt_q, wcnt_d;
    logic            terr_q, terr_d;
    logic            push, pop;

    // The timer's counting status is observed by software only; it never steers the FSM.
    logic unused_counting;
    assign unused_counting = counting;

    assign cmd_ready = (count_q != CntW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_delay;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = {4'b1101, fifo_q[rd_ptr_q]};
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                shift_d = {shift_q[6:0], 1'b0};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    wcnt_d  = '0;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                // done wins over a timeout landing on the same cycle.
                if (done) begin
                    state_d = StAck;
                end else if (wcnt_q == TimeoutLast) begin
                    terr_d  = 1'b1;
                    state_d = StGap;
                end else begin
                    wcnt_d = wcnt_q + 15'd1;
                end
            end
            StAck:   state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign data        = (state_q == StSend) && shift_q[7];
    assign ack         = (state_q == StAck);
    assign cmd_done    = (state_q == StAck);
    assign busy        = (state_q != StIdle);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fancytimer_driver.sv
// Randomized bench for fancytimer_driver: a queue of expected frames (delay code, done latency,
// acceptance cycle) is consumed by a monitor that also plays the timer's done response.
module tb_fancytimer_driver;

    localparam int D = 4;
    localparam int T = 16;

    typedef struct {
        logic [3:0] d;
        int         k;
        int         acc;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [3:0] cmd_delay;
    logic       cmd_ready;
    logic       data;
    logic       counting;
    logic       done;
    logic       ack;
    logic       busy;
    logic       cmd_done;
    logic       timeout_err;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    stim_done = 1'b0;
    item_t sb[$];

    fancytimer_driver #(
        .FIFO_DEPTH    (D),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_delay  (cmd_delay),
        .cmd_ready  (cmd_ready),
        .data       (data),
        .counting   (counting),
        .done       (done),
        .ack        (ack),
        .busy       (busy),
        .cmd_done   (cmd_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Called at a negedge; returns at the next negedge with the accepted item queued.
    task automatic drive(input bit v, input logic [3:0] d, input int k);
        bit acc;
        cmd_valid = v;
        cmd_delay = d;
        counting  = 1'($urandom_range(0, 1));
        acc       = v && cmd_ready;
        @(negedge clk);
        if (acc) sb.push_back('{d: d, k: k, acc: cyc});
    endtask

    task automatic monitor();
        int         idle_c, waitc, exp_start, endj;
        bit         te_m, fin, got, ackcase;
        item_t      it;
        logic [7:0] bits;
        idle_c = cyc;
        te_m   = 1'b0;
        fin    = 1'b0;
        while (!fin) begin
            waitc = 0;
            got   = 1'b0;
            while (!got && !fin) begin
                @(negedge clk);
                if (data === 1'b1) begin
                    got = 1'b1;
                end else if (stim_done && sb.size() == 0) begin
                    fin = 1'b1;
                end else if (sb.size() != 0) begin
                    waitc++;
                    if (waitc > 400) begin
                        fail("frame_start_timeout");
                        fin = 1'b1;
                    end
                end
            end
            if (got && sb.size() == 0) begin
                fail("unexpected_frame");
                fin = 1'b1;
            end else if (got) begin
                it = sb.pop_front();
                // Pop happens at the end of the first cycle that is both idle and non-empty.
                exp_start = ((it.acc > idle_c) ? it.acc : idle_c) + 1;
                chk("start_cycle", cyc, exp_start);
                bits[7] = data;
                for (int b = 6; b >= 0; b--) begin
                    @(negedge clk);
                    bits[b] = data;
                end
                chk("frame_bits", 32'(bits), 32'({4'b1101, it.d}));
                ackcase = (it.k <= T - 1);
                endj    = ackcase ? it.k + 4 : T + 2;
                for (int j = 1; j <= endj; j++) begin
                    @(negedge clk);
                    if (!ackcase && j == T + 1) te_m = 1'b1;
                    chk("ack", 32'(ack), 32'(ackcase && j == it.k + 2));
                    chk("cmd_done", 32'(cmd_done), 32'(ackcase && j == it.k + 2));
                    chk("busy", 32'(busy), 32'(j < endj));
                    chk("data_quiet", 32'(data), 32'(0));
                    chk("timeout_err", 32'(timeout_err), 32'(te_m));
                    done = (j == it.k + 1);
                end
                done   = 1'b0;
                idle_c = cyc;
            end
        end
    endtask

    task automatic stimulus();
        logic [3:0] bd[5];
        int         bk[5];
        bd = '{4'h9, 4'h6, 4'hC, 4'h0, 4'hF};
        bk = '{T - 1, 3, T, 0, T};
        drive(1'b1, 4'h2, 5);
        cmd_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("ready_idle", 32'(cmd_ready), 32'(1));
        // One pop happens right after the first push, so four more fill the FIFO.
        for (int i = 0; i < 5; i++) begin
            chk("burst_ready", 32'(cmd_ready), 32'(1));
            drive(1'b1, bd[i], bk[i]);
        end
        chk("burst_full", 32'(cmd_ready), 32'(0));
        drive(1'b1, 4'h7, 0);
        chk("full_hold", 32'(cmd_ready), 32'(0));
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) == 0, 4'($urandom()), int'($urandom_range(0, T)));
        end
        cmd_valid = 1'b0;
        stim_done = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_delay = 4'h0;
        counting  = 1'b0;
        done      = 1'b0;
        #12;
        chk("rst_data", 32'(data), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cmd_done", 32'(cmd_done), 32'(0));
        chk("rst_timeout_err", 32'(timeout_err), 32'(0));
        chk("rst_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'(0));

        // Frame for 4'hA is 1,1,0,1,1,0,1,0; reset lands during bit 5.
        drive(1'b1, 4'hA, 0);
        drive(1'b1, 4'h3, 0);
        chk("latency_bit1", 32'(data), 32'(1));
        drive(1'b1, 4'h5, 0);
        chk("bit2", 32'(data), 32'(1));
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bit5_data", 32'(data), 32'(1));
        chk("bit5_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        #1;
        chk("abort_data", 32'(data), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ack", 32'(ack), 32'(0));
        chk("abort_ready", 32'(cmd_ready), 32'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("lost_data", 32'(data), 32'(0));
            chk("lost_ready", 32'(cmd_ready), 32'(1));
            chk("lost_busy", 32'(busy), 32'(0));
        end

        fork
            monitor();
            stimulus();
        join
        chk("drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
